// File: rtl/fetch_request_unit.sv
// ============================================================================
// fetch_request_unit : multi-cycle fetch/exec/mem sequencer with next-PC select
// Option macro FETCH_PERF_CNT_EN enables the retired-instruction counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_request_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic [31:0] iload,
   input  logic        dhit,
   input  logic [1:0]  PCsrc,
   input  logic        branch_taken,
   input  logic [31:0] rs_data,
   input  logic        dREN_in,
   input  logic        dWEN_in,
   input  logic        halt_in,
   output logic [31:0] imemaddr,
   output logic        iREN,
   output logic [31:0] instr,
   output logic [31:0] pc_plus4,
   output logic        dREN,
   output logic        dWEN,
   output logic        halt,
   output logic [31:0] retired_cnt
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      EXEC   = 2'd1,
      MEM    = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic [31:0] instr_q;
   logic [31:0] instr_next;
   logic        dren_q;
   logic        dren_next;
   logic        dwen_q;
   logic        dwen_next;
   logic [31:0] seq_pc;
   logic [31:0] branch_off;
   logic [31:0] target;

   assign seq_pc     = pc + 32'd4;
   assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

   always_comb begin
      target = seq_pc;
      case (PCsrc)
         2'b00:   target = seq_pc;
         2'b01:   target = {seq_pc[31:28], instr_q[25:0], 2'b00};
         2'b10:   target = branch_taken ? (seq_pc + branch_off) : seq_pc;
         default: target = rs_data;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      instr_next = instr_q;
      dren_next  = dren_q;
      dwen_next  = dwen_q;
      case (state)
         FETCH: begin
            if (ihit) begin
               instr_next = iload;
               state_next = EXEC;
            end
         end
         EXEC: begin
            if (halt_in) begin
               state_next = HALTED;
            end else if (dREN_in || dWEN_in) begin
               dren_next  = dREN_in;
               dwen_next  = dWEN_in;
               state_next = MEM;
            end else begin
               pc_next    = target;
               state_next = FETCH;
            end
         end
         MEM: begin
            // Decode inputs are only sampled on EXEC exit; MEM holds the latched copy.
            if (dhit) begin
               dren_next  = 1'b0;
               dwen_next  = 1'b0;
               pc_next    = target;
               state_next = FETCH;
            end
         end
         default: begin
            state_next = HALTED;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pc      <= PC_INIT;
         instr_q <= 32'h0;
         dren_q  <= 1'b0;
         dwen_q  <= 1'b0;
      end else begin
         pc      <= pc_next;
         instr_q <= instr_next;
         dren_q  <= dren_next;
         dwen_q  <= dwen_next;
      end
   end

   assign imemaddr = pc;
   assign instr    = instr_q;
   assign pc_plus4 = seq_pc;
   assign iREN     = (state == FETCH);
   assign halt     = (state == HALTED);
   assign dREN     = dren_q;
   assign dWEN     = dwen_q;

`ifdef FETCH_PERF_CNT_EN
   logic        retire;
   logic [31:0] retired_q;

   // HALTED never re-enters FETCH without reset, so this covers EXEC/MEM exits only.
   assign retire = (state != FETCH) && (state_next == FETCH);

   always_ff @(posedge CLK) begin
      if (RST) begin
         retired_q <= 32'h0;
      end else if (retire) begin
         retired_q <= retired_q + 32'd1;
      end
   end

   assign retired_cnt = retired_q;
`else
   assign retired_cnt = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_request_unit.sv
// Randomized scoreboard bench for fetch_request_unit against an instruction-level model.
`default_nettype none

module tb_fetch_request_unit;

   localparam logic [31:0] PC_INIT = 32'h0000_0000;
   localparam int EV_FETCH = 0;
   localparam int EV_DATA  = 1;
   localparam int EV_HALT  = 2;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        ihit = 1'b0;
   logic [31:0] iload = 32'h0;
   logic        dhit = 1'b0;
   logic [1:0]  PCsrc = 2'b00;
   logic        branch_taken = 1'b0;
   logic [31:0] rs_data = 32'h0;
   logic        dREN_in = 1'b0;
   logic        dWEN_in = 1'b0;
   logic        halt_in = 1'b0;
   logic [31:0] imemaddr;
   logic        iREN;
   logic [31:0] instr;
   logic [31:0] pc_plus4;
   logic        dREN;
   logic        dWEN;
   logic        halt;
   logic [31:0] retired_cnt;

   fetch_request_unit #(.PC_INIT(PC_INIT)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .dhit(dhit),
      .PCsrc(PCsrc), .branch_taken(branch_taken), .rs_data(rs_data),
      .dREN_in(dREN_in), .dWEN_in(dWEN_in), .halt_in(halt_in),
      .imemaddr(imemaddr), .iREN(iREN), .instr(instr), .pc_plus4(pc_plus4),
      .dREN(dREN), .dWEN(dWEN), .halt(halt), .retired_cnt(retired_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          kind;
      logic [31:0] pc;
      logic [31:0] ins;
      logic [1:0]  dv;
      logic [31:0] cnt;
   } ev_t;

   ev_t         expq[$];
   int          compared = 0;
   int          mismatched = 0;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ev_t make_ev(input int kind, input logic [31:0] pc, input logic [31:0] ins,
                                   input logic [1:0] dv, input logic [31:0] cnt);
      ev_t e;
      e.kind = kind; e.pc = pc; e.ins = ins; e.dv = dv; e.cnt = cnt;
      return e;
   endfunction

   function automatic logic [31:0] exp_cnt();
`ifdef FETCH_PERF_CNT_EN
      return m_cnt;
`else
      return 32'h0;
`endif
   endfunction

   // Architectural next-PC rule, written as plain arithmetic.
   function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] word,
                                           input logic [1:0] src, input logic bt,
                                           input logic [31:0] rs);
      logic [31:0] seq;
      int          off;
      seq = pc + 32'd4;
      off = $signed(word[15:0]);
      off = off * 4;
      case (src)
         2'd0:    return seq;
         2'd1:    return {seq[31:28], word[25:0], 2'b00};
         2'd2:    return bt ? seq + 32'(off) : seq;
         default: return rs;
      endcase
   endfunction

   task automatic push_fetch();
      expq.push_back(make_ev(EV_FETCH, m_pc, m_instr, 2'b00, exp_cnt()));
   endtask

   task automatic do_reset();
      RST = 1'b1;
      ihit = 1'b0; dhit = 1'b0; halt_in = 1'b0; dREN_in = 1'b0; dWEN_in = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b0;
      m_pc = PC_INIT; m_instr = 32'h0; m_cnt = 32'h0;
      push_fetch();
   endtask

   task automatic run_instr(input logic [31:0] word, input logic [1:0] src, input logic bt,
                            input logic [31:0] rs, input logic dr, input logic dw,
                            input logic hl, input int lat, input bit abort);
      int wait_cycles;
      wait_cycles = $urandom_range(0, 2);
      repeat (wait_cycles) begin
         ihit = 1'b0; dhit = 1'($urandom); iload = $urandom;
         @(posedge CLK); #1;
      end
      ihit = 1'b1; iload = word; dhit = 1'($urandom);
      @(posedge CLK); #1;
      m_instr = word;
      ihit = 1'($urandom); iload = $urandom; dhit = 1'($urandom);
      PCsrc = src; branch_taken = bt; rs_data = rs;
      dREN_in = dr; dWEN_in = dw; halt_in = hl;
      if (hl) begin
         expq.push_back(make_ev(EV_HALT, m_pc, m_instr, 2'b00, 32'h0));
         @(posedge CLK); #1;
         repeat (4) begin
            ihit = 1'b1; dhit = 1'($urandom); halt_in = 1'($urandom);
            @(posedge CLK); #1;
         end
         do_reset();
         return;
      end
      if (dr || dw) begin
         expq.push_back(make_ev(EV_DATA, m_pc, m_instr, {dr, dw}, 32'h0));
         @(posedge CLK); #1;
         repeat (lat) begin
            dhit = 1'b0; ihit = 1'($urandom); iload = $urandom;
            dREN_in = 1'($urandom); dWEN_in = 1'($urandom); halt_in = 1'($urandom);
            @(posedge CLK); #1;
         end
         if (abort) begin
            do_reset();
            return;
         end
         dhit = 1'b1; ihit = 1'($urandom);
         @(posedge CLK); #1;
      end else begin
         @(posedge CLK); #1;
      end
      m_pc = next_pc(m_pc, word, src, bt, rs);
      m_cnt = m_cnt + 32'd1;
      push_fetch();
      ihit = 1'b0; dhit = 1'b0; dREN_in = 1'b0; dWEN_in = 1'b0; halt_in = 1'b0;
   endtask

   // Monitor: pops one expected event per observed DUT presentation.
   logic        prev_iren = 1'b0;
   logic        prev_halt = 1'b0;
   logic        mem_active = 1'b0;
   logic        mem_release = 1'b0;
   logic [1:0]  mem_val = 2'b00;
   logic [31:0] halt_pc = 32'h0;

   task automatic pop_ev(input int want, output ev_t e);
      if (expq.size() == 0) begin
         check("event_queue_nonempty", 32'd0, 32'd1);
         e = make_ev(-1, 32'h0, 32'h0, 2'b00, 32'h0);
      end else begin
         e = expq.pop_front();
      end
      check("event_kind", 32'(e.kind), 32'(want));
   endtask

   always @(negedge CLK) begin
      ev_t e;
      if (RST) begin
         prev_iren = 1'b0; prev_halt = 1'b0; mem_active = 1'b0; mem_release = 1'b0;
      end else begin
         if (iREN && !prev_iren) begin
            pop_ev(EV_FETCH, e);
            check("fetch_imemaddr", imemaddr, e.pc);
            check("fetch_instr", instr, e.ins);
            check("fetch_retired_cnt", retired_cnt, e.cnt);
            check("fetch_halt_dren_dwen", {29'h0, halt, dREN, dWEN}, 32'h0);
         end
         if (mem_active) begin
            check("mem_hold_dren_dwen", {30'h0, dREN, dWEN},
                  mem_release ? 32'h0 : {30'h0, mem_val});
            if (mem_release) mem_active = 1'b0;
            else mem_release = dhit;
         end else if (dREN || dWEN) begin
            pop_ev(EV_DATA, e);
            check("mem_dren_dwen", {30'h0, dREN, dWEN}, {30'h0, e.dv});
            check("mem_imemaddr", imemaddr, e.pc);
            check("mem_pc_plus4", pc_plus4, e.pc + 32'd4);
            check("mem_instr", instr, e.ins);
            mem_active = 1'b1; mem_val = e.dv; mem_release = dhit;
         end
         if (halt && !prev_halt) begin
            pop_ev(EV_HALT, e);
            check("halt_instr", instr, e.ins);
            halt_pc = e.pc;
         end
         if (halt) begin
            check("halted_requests", {29'h0, iREN, dREN, dWEN}, 32'h0);
            check("halted_pc", imemaddr, halt_pc);
         end
         prev_iren = iREN;
         prev_halt = halt;
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: compared %0d", compared);
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0] src;
      logic       dr, dw, hl;
      repeat (2) @(posedge CLK);
      #1;
      do_reset();
      run_instr(32'h3C01_0001, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_instr(32'h8C22_0000, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 3, 1'b0);
      run_instr(32'h0000_0008, 2'd3, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_instr(32'h1000_FFFF, 2'd2, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_instr(32'h1000_FFFF, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_instr(32'h0000_0008, 2'd3, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_instr(32'h0C00_0100, 2'd1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_instr(32'h0000_0008, 2'd3, 1'b0, 32'h44, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_instr(32'h0000_0008, 2'd3, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_instr(32'h0000_0000, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_instr(32'hAC22_0000, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      run_instr(32'hAC22_0004, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2, 1'b1);
      run_instr(32'hFFFF_FFFF, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      for (int i = 0; i < 200; i++) begin
         src = 2'($urandom);
         dr = 1'b0; dw = 1'b0;
         if ($urandom_range(0, 9) < 3) begin
            case ($urandom_range(0, 2))
               0:       dr = 1'b1;
               1:       dw = 1'b1;
               default: begin dr = 1'b1; dw = 1'b1; end
            endcase
         end
         hl = ($urandom_range(0, 99) < 3);
         run_instr($urandom, src, 1'($urandom), $urandom & 32'hFFFF_FFFC, dr, dw, hl,
                   $urandom_range(0, 4), ($urandom_range(0, 99) < 2));
      end
      repeat (3) @(posedge CLK);
      #1;
      check("queue_drained", 32'(expq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_request_unit.md
FETCH_REQUEST_UNIT -- requirements
Module: fetch_request_unit

Interface
REQ-001 Parameter: PC_INIT, 32'h00000000, PC value loaded on reset.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 RST  in  1  synchronous active-high reset.
REQ-005 ihit  in  1  instruction memory read complete; iload valid this cycle.
REQ-006 iload  in  32  instruction word from instruction memory.
REQ-007 dhit  in  1  data memory access complete.
REQ-008 PCsrc  in  2  next-PC select from decode: 00 pc+4, 01 jump, 10 branch, 11 register.
REQ-009 branch_taken  in  1  branch condition result from datapath.
REQ-010 rs_data  in  32  register target for PCsrc=11.
REQ-011 dREN_in, dWEN_in, halt_in  in  1 each  decode requests for the current instruction.
REQ-012 imemaddr  out  32  current PC.
REQ-013 iREN  out  1  instruction read request.
REQ-014 instr  out  32  latched instruction fed to decode.
REQ-015 pc_plus4  out  32  PC+4, used for JAL link data.
REQ-016 dREN, dWEN  out  1 each  data memory requests.
REQ-017 halt  out  1  sticky halt.
REQ-018 retired_cnt  out  32  retired-instruction count (see Configuration).

Function
REQ-019 States: FETCH, EXEC, MEM, HALTED; FETCH on reset.
REQ-020 FETCH: iREN=1; on ihit latch iload into instr, go to EXEC; else stay.
REQ-021 EXEC: iREN=0; halt_in=1 -> HALTED with PC unchanged; otherwise dREN_in|dWEN_in -> MEM; otherwise load next PC and go to FETCH.
REQ-022 MEM: dREN and dWEN equal the values of dREN_in and dWEN_in latched on EXEC exit and hold until dhit; on dhit clear both in the same edge, load next PC, go to FETCH.
REQ-023 HALTED: absorbing until RST; halt=1, iREN=dREN=dWEN=0; PC and instr frozen.
REQ-024 Next PC for PCsrc 00: pc+4, modulo 2^32 (0xFFFFFFFC wraps to 0).
REQ-025 Next PC for PCsrc 01: {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-026 Next PC for PCsrc 10: pc+4+(sign-extended instr[15:0]<<2) if branch_taken, else pc+4; all sums modulo 2^32.
REQ-027 Next PC for PCsrc 11: rs_data.
REQ-028 ihit is ignored outside FETCH; dhit is ignored outside MEM; simultaneous ihit and dhit act only on the hit matching the state.
REQ-029 The PC register and instr change only on the edges defined above; every request output is registered-state derived, with no combinational path from ihit or dhit.

Reset
REQ-030 RST=1 at a clock edge: state=FETCH, PC=PC_INIT, instr=0, dREN=dWEN=halt=0, retired_cnt=0; iREN=1 from the first cycle after reset.
REQ-031 Reset during MEM or HALTED aborts the operation; pending dREN and dWEN drop at that edge.

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN defined: retired_cnt increments by 1 on each EXEC->FETCH or MEM->FETCH transition, wraps at 2^32, and freezes in HALTED.
REQ-033 Macro FETCH_PERF_CNT_EN undefined: retired_cnt is tied to 0 and no counter register exists.

Verification
REQ-034 Reset then ihit with iload=0x3C010001, PCsrc=00: instr=0x3C010001, PC goes 0 -> 4 two cycles after ihit.
REQ-035 LW: dREN_in=1, dhit withheld 3 cycles: dREN held high for 3 cycles, drops on dhit, and the next iREN has imemaddr=PC+4.
REQ-036 BEQ at PC=0x10 with imm=0xFFFF, branch_taken=1: next PC=0x10; with branch_taken=0: next PC=0x14.
REQ-037 JAL at PC=0x40 with target field 0x000100: pc_plus4=0x44, next PC=0x400; JR with rs_data=0x44: next PC=0x44.
REQ-038 halt_in=1 in EXEC: halt asserts and stays high; iREN stays 0 under repeated ihit; after RST, PC=PC_INIT and halt=0.
REQ-039 PC=0xFFFFFFFC with PCsrc=00: next PC=0; with FETCH_PERF_CNT_EN defined, retired_cnt=N after N non-memory instructions.
